// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the single-port data_mem.
// The master side carries both requesters and the memory read-data return.
`timescale 1ns/1ps
interface dmem_arbiter_if;
  logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [7:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [7:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [7:0]  mem_r_address, mem_w_address;
  logic [31:0] mem_w_data, mem_o_data;
  logic        mem_w_enable;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
    output mem_r_address, mem_w_address, mem_w_data, mem_w_enable,
    input  mem_o_data
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
    input  mem_r_address, mem_w_address, mem_w_data, mem_w_enable,
    output mem_o_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_mem between the CPU MEM stage (port 0) and a loader (port 1),
// with a bounded lock so an owner can burst but never starve the other port.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int P0_FIRST  = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OWN0    = 2'd1;
  localparam logic [1:0] S_OWN1    = 2'd2;
  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  localparam logic       RR_INIT   = (P0_FIRST != 0) ? 1'b0 : 1'b1;

  logic [1:0]  state;
  logic        rr;
  logic [3:0]  burst_cnt;
  logic        gnt0, gnt1, handover;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign handover = (burst_cnt >= BURST_LIM);

  // Grant: an owner keeps the bus until its burst limit is reached while the other port waits.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (state == S_OWN0 && bus.p0_req) begin
        if (handover && bus.p1_req) gnt1 = 1'b1;
        else                        gnt0 = 1'b1;
      end else if (state == S_OWN1 && bus.p1_req) begin
        if (handover && bus.p0_req) gnt0 = 1'b1;
        else                        gnt1 = 1'b1;
      end else if (bus.p0_req && bus.p1_req) begin
        gnt0 = ~rr;
        gnt1 = rr;
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;

  always_comb begin
    bus.mem_r_address = '0;
    bus.mem_w_address = '0;
    bus.mem_w_data    = '0;
    if (gnt0) begin
      bus.mem_r_address = bus.p0_addr;
      bus.mem_w_address = bus.p0_addr;
      bus.mem_w_data    = bus.p0_wdata;
    end else if (gnt1) begin
      bus.mem_r_address = bus.p1_addr;
      bus.mem_w_address = bus.p1_addr;
      bus.mem_w_data    = bus.p1_wdata;
    end
    bus.mem_w_enable = (gnt0 & bus.p0_we) | (gnt1 & bus.p1_we);
  end

  // Ownership, tie-break and burst tracking; every accept hands the next tie to the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr        <= RR_INIT;
      burst_cnt <= '0;
    end else if (gnt0) begin
      rr <= 1'b1;
      if (bus.p0_lock) begin
        state     <= S_OWN0;
        burst_cnt <= (state == S_OWN0) ? sat_inc(burst_cnt) : 4'd1;
      end else begin
        state     <= S_IDLE;
        burst_cnt <= '0;
      end
    end else if (gnt1) begin
      rr <= 1'b0;
      if (bus.p1_lock) begin
        state     <= S_OWN1;
        burst_cnt <= (state == S_OWN1) ? sat_inc(burst_cnt) : 4'd1;
      end else begin
        state     <= S_IDLE;
        burst_cnt <= '0;
      end
    end else if ((state == S_OWN0 && !bus.p0_req) || (state == S_OWN1 && !bus.p1_req)) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
    end
  end

  // Read return stage: capture the combinational memory word at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~bus.p0_we;
      rvalid1 <= gnt1 & ~bus.p1_we;
      if (gnt0 & ~bus.p0_we) rdata0 <= bus.mem_o_data;
      if (gnt1 & ~bus.p1_we) rdata1 <= bus.mem_o_data;
    end
  end

  assign bus.p0_rvalid = rvalid0;
  assign bus.p1_rvalid = rvalid1;
  assign bus.p0_rdata  = rdata0;
  assign bus.p1_rdata  = rdata1;
endmodule
